// File: rtl/stateful_egress_pkg.sv
// Shared definitions for the stateful match stage and its egress stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: action word field positions, stamp byte geometry, egress FSM encoding.
package stateful_egress_pkg;

    // Action word layout: [15:8] egress port bitmap, [7:0] stamp enable.
    localparam int ACTION_W  = 16;
    localparam int PORT_MSB  = 15;
    localparam int PORT_LSB  = 8;
    localparam int STAMP_MSB = 7;
    localparam int STAMP_LSB = 0;
    localparam int PORT_W    = PORT_MSB - PORT_LSB + 1;

    // State value width; when stamping it replaces the most significant
    // byte of the packet word.
    localparam int STATE_W   = 8;
    localparam int STAMP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_SEND   = 2'd3
    } eg_state_e;

    // A zero port bitmap means the packet is dropped.
    function automatic logic is_drop(input logic [ACTION_W-1:0] action);
        return (action[PORT_MSB:PORT_LSB] == '0);
    endfunction

    function automatic logic is_stamp(input logic [ACTION_W-1:0] action);
        return (action[STAMP_MSB:STAMP_LSB] != '0);
    endfunction

endpackage

// File: rtl/egress_fifo.sv
// Synchronous FIFO with registered read data, parameterised width and depth.
// Latency: dout valid the cycle after rd_en; write visible in count the cycle after wr_en.
// Backpressure: writes while full are discarded, reads while empty are ignored.
// Ports: clk/reset (async, active-high), wr_en/din push, rd_en pop,
//        dout registered head, empty/full/count from the pre-edge occupancy.
module egress_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_BITS:0]   count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  do_wr, do_rd;

    // Flags come from the registered count, so a pop in the same cycle
    // never frees space for a push.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = dout_q;

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        count_d = count_q + (DEPTH_BITS+1)'(do_wr) - (DEPTH_BITS+1)'(do_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/stateful_egress.sv
// Egress stage: buffers the match-stage stream, applies forward/stamp/drop, presents valid/ready output.
// Latency: pkt_vld_in at edge N -> out_vld high after edge N+3 (empty FIFO, idle FSM).
// Backpressure: none upstream (overflow drops counted); out_vld/out_data/out_port held until out_rdy.
// Ports: pkt_vld_in/pkt_data_in/action_in/state_in in; out_vld/out_rdy/out_data/out_port egress;
//        fwd_cnt/drop_cnt saturating statistics; overflow sticky lost-input flag.
module stateful_egress
    import stateful_egress_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int DEPTH_BITS = 3,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_vld_in,
    input  logic [DATA_W-1:0]   pkt_data_in,
    input  logic [ACTION_W-1:0] action_in,
    input  logic [STATE_W-1:0]  state_in,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [DATA_W-1:0]   out_data,
    output logic [PORT_W-1:0]   out_port,
    output logic [CNT_W-1:0]    fwd_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                overflow
);

    localparam int ENTRY_W = DATA_W + ACTION_W + STATE_W;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // FIFO
    logic                 fifo_rd;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DEPTH_BITS:0]  fifo_count;

    egress_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (pkt_vld_in),
        .din   ({pkt_data_in, action_in, state_in}),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // The FIFO's registered read port acts as the evaluation register:
    // it is loaded in FETCH and examined in DECIDE.
    logic [DATA_W-1:0]   head_data;
    logic [ACTION_W-1:0] head_action;
    logic [STATE_W-1:0]  head_state;

    assign head_data   = fifo_dout[ENTRY_W-1 -: DATA_W];
    assign head_action = fifo_dout[STATE_W +: ACTION_W];
    assign head_state  = fifo_dout[STATE_W-1:0];

    // FSM and registered outputs
    eg_state_e          state_q, state_d;
    logic               out_vld_q, out_vld_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [PORT_W-1:0]  out_port_q, out_port_d;
    logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               ovf_drop;
    logic               act_drop;

    always_comb begin
        state_d    = state_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_port_d = out_port_q;
        fwd_cnt_d  = fwd_cnt_q;
        overflow_d = overflow_q;
        fifo_rd    = 1'b0;
        act_drop   = 1'b0;

        // A push against a full FIFO is lost, even if FETCH pops this cycle.
        ovf_drop = pkt_vld_in && fifo_full;
        if (ovf_drop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fifo_rd = !fifo_empty;
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (is_drop(head_action)) begin
                    act_drop = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    out_data_d = head_data;
                    if (is_stamp(head_action)) begin
                        out_data_d[DATA_W-1 -: STAMP_W] = head_state;
                    end
                    out_port_d = head_action[PORT_MSB:PORT_LSB];
                    out_vld_d  = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    fwd_cnt_d = sat_add(fwd_cnt_q, 2'd1);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Overflow and action drops in the same cycle both count.
        drop_cnt_d = sat_add(drop_cnt_q, {1'b0, ovf_drop} + {1'b0, act_drop});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_port_q <= '0;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_port_q <= out_port_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_port = out_port_q;
    assign fwd_cnt  = fwd_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stateful_egress.sv
// Directed bench for stateful_egress: vector table of single packets plus
// backpressure, overflow/drain and asynchronous-reset sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_stateful_egress;

    logic         clk = 1'b0;
    logic         reset;
    logic         pkt_vld_in;
    logic [511:0] pkt_data_in;
    logic [15:0]  action_in;
    logic [7:0]   state_in;
    logic         out_vld;
    logic         out_rdy;
    logic [511:0] out_data;
    logic [7:0]   out_port;
    logic [31:0]  fwd_cnt;
    logic [31:0]  drop_cnt;
    logic         overflow;

    int tests = 0;
    int fails = 0;
    int exp_fwd = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    stateful_egress #(
        .DATA_W     (512),
        .DEPTH_BITS (3),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_vld_in  (pkt_vld_in),
        .pkt_data_in (pkt_data_in),
        .action_in   (action_in),
        .state_in    (state_in),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_port    (out_port),
        .fwd_cnt     (fwd_cnt),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    typedef struct {
        logic [511:0] data;
        logic [15:0]  action;
        logic [7:0]   state;
        logic         fwd;
        logic [7:0]   port;
        logic [511:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    logic [511:0] ovf_data[12];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one packet for exactly one rising edge.
    task automatic push(input logic [511:0] d, input logic [15:0] a, input logic [7:0] s);
        pkt_vld_in  = 1'b1;
        pkt_data_in = d;
        action_in   = a;
        state_in    = s;
        wait_edges(1);
        pkt_vld_in  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{{64{8'hA5}}, 16'h0300, 8'h07, 1'b1, 8'h03, {64{8'hA5}}};
        vecs[1] = '{{64{8'h5A}}, 16'h0101, 8'h42, 1'b1, 8'h01, {8'h42, {63{8'h5A}}}};
        vecs[2] = '{{64{8'h3C}}, 16'h00FF, 8'h11, 1'b0, 8'h00, 512'h0};
        vecs[3] = '{{8{64'h0123456789ABCDEF}}, 16'h8000, 8'h99, 1'b1, 8'h80, {8{64'h0123456789ABCDEF}}};
        vecs[4] = '{{8{64'hFEDCBA9876543210}}, 16'hFF80, 8'h3C, 1'b1, 8'hFF,
                    {8'h3C, 56'hDCBA9876543210, {7{64'hFEDCBA9876543210}}}};
        vecs[5] = '{{64{8'hEE}}, 16'h0000, 8'h55, 1'b0, 8'h00, 512'h0};
        for (int i = 0; i < 12; i++) begin
            ovf_data[i] = {16{32'hC0DE0000 + 32'(i)}};
        end

        reset       = 1'b1;
        pkt_vld_in  = 1'b0;
        pkt_data_in = '0;
        action_in   = '0;
        state_in    = '0;
        out_rdy     = 1'b1;
        wait_edges(3);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_port", out_port, 0);
        chk("reset_fwd_cnt", fwd_cnt, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        wait_edges(1);

        // Table: one packet at a time, out_rdy high.
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].data, vecs[i].action, vecs[i].state);
            wait_edges(2);
            chk($sformatf("v%0d_vld_early", i), out_vld, 0);
            wait_edges(1);
            chk($sformatf("v%0d_vld", i), out_vld, vecs[i].fwd);
            if (vecs[i].fwd) begin
                chk($sformatf("v%0d_port", i), out_port, vecs[i].port);
                chk($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
                exp_fwd++;
                wait_edges(1);
                chk($sformatf("v%0d_vld_after", i), out_vld, 0);
                chk($sformatf("v%0d_fwd_cnt", i), fwd_cnt, 32'(exp_fwd));
            end else begin
                exp_drop++;
                chk($sformatf("v%0d_drop_cnt", i), drop_cnt, 32'(exp_drop));
                chk($sformatf("v%0d_fwd_hold", i), fwd_cnt, 32'(exp_fwd));
            end
        end

        // Backpressure: held for 10 cycles, then one transfer.
        out_rdy = 1'b0;
        push({64{8'h77}}, 16'h0200, 8'h11);
        wait_edges(3);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_vld_%0d", i), out_vld, 1);
            chk($sformatf("bp_data_%0d", i), out_data, {64{8'h77}});
            chk($sformatf("bp_port_%0d", i), out_port, 8'h02);
            wait_edges(1);
        end
        chk("bp_fwd_before", fwd_cnt, 32'(exp_fwd));
        out_rdy = 1'b1;
        wait_edges(1);
        exp_fwd++;
        chk("bp_vld_after", out_vld, 0);
        chk("bp_fwd_cnt", fwd_cnt, 32'(exp_fwd));

        // Overflow: 12 back-to-back with out_rdy low -> 1 in SEND, 8 queued, 3 lost.
        out_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push(ovf_data[i], 16'h0400, 8'h00);
        end
        exp_drop += 3;
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 32'(exp_drop));
        chk("ovf_head_vld", out_vld, 1);
        chk("ovf_head_data", out_data, ovf_data[0]);
        out_rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 20 && !out_vld; t++) begin
                wait_edges(1);
            end
            chk($sformatf("drain_vld_%0d", k), out_vld, 1);
            chk($sformatf("drain_data_%0d", k), out_data, ovf_data[k]);
            wait_edges(1);
        end
        exp_fwd += 9;
        wait_edges(6);
        chk("drain_none_left", out_vld, 0);
        chk("drain_fwd_cnt", fwd_cnt, 32'(exp_fwd));
        chk("drain_drop_cnt", drop_cnt, 32'(exp_drop));
        chk("drain_overflow_sticky", overflow, 1);

        // Async reset mid-SEND with the FIFO occupied.
        out_rdy = 1'b0;
        push({64{8'h99}}, 16'h0800, 8'h00);
        push({64{8'h98}}, 16'h0800, 8'h00);
        push({64{8'h97}}, 16'h0800, 8'h00);
        wait_edges(2);
        chk("rst_pre_vld", out_vld, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_vld", out_vld, 0);
        chk("rst_async_data", out_data, 0);
        chk("rst_async_fwd", fwd_cnt, 0);
        chk("rst_async_drop", drop_cnt, 0);
        chk("rst_async_ovf", overflow, 0);
        wait_edges(2);
        #3;
        reset = 1'b0;
        exp_fwd = 0;
        exp_drop = 0;
        out_rdy = 1'b1;
        wait_edges(8);
        chk("rst_fifo_empty", out_vld, 0);
        chk("rst_fwd_still0", fwd_cnt, 0);
        push({64{8'h12}}, 16'h1001, 8'hAB);
        wait_edges(2);
        chk("post_rst_vld_early", out_vld, 0);
        wait_edges(1);
        chk("post_rst_vld", out_vld, 1);
        chk("post_rst_port", out_port, 8'h10);
        chk("post_rst_data", out_data, {8'hAB, {63{8'h12}}});
        wait_edges(1);
        exp_fwd++;
        chk("post_rst_fwd", fwd_cnt, 32'(exp_fwd));
        chk("post_rst_drop", drop_cnt, 32'(exp_drop));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
